// File: rtl/exc_commit.sv
// Writeback commit unit: prioritises interrupt/exception/ERTN/refetch events and hands them to the CSR block.
// Optional feature macro EXC_TIMEOUT_EN: aborts WAIT after TIMEOUT_CYC cycles without exlike and sets err_timeout.
module exc_commit #(
    parameter int unsigned TIMEOUT_CYC = 8
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        wb_valid,
    output logic        wb_ready,
    input  logic [31:0] wb_pc,
    input  logic [14:0] wb_exc,
    input  logic [31:0] wb_badv,
    input  logic        wb_is_ertn,
    input  logic        wb_is_refetch,
    input  logic [11:0] lie,
    input  logic [11:0] is,
    input  logic        ie,
    input  logic        exlike,
    output logic        is_exc,
    output logic        is_ertn,
    output logic        is_fetch_again,
    output logic [5:0]  excode,
    output logic [8:0]  esubcode,
    output logic [31:0] badvaddr,
    output logic [31:0] csr_pc,
    output logic        flush,
    output logic        err_timeout
);

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT} state_t;
    state_t state;

    logic        int_pend;
    logic        nxt_exc;
    logic        nxt_ertn;
    logic        nxt_refetch;
    logic [3:0]  sel;
    logic [5:0]  nxt_excode;
    logic [8:0]  nxt_esubcode;
    logic [31:0] nxt_badv;

    assign int_pend = ie & (|(lie & is));
    assign wb_ready = (state == IDLE);
    assign flush    = (state != IDLE);

    always_comb begin
        nxt_exc      = 1'b0;
        nxt_ertn     = 1'b0;
        nxt_refetch  = 1'b0;
        sel          = 4'd0;
        nxt_excode   = '0;
        nxt_esubcode = '0;
        nxt_badv     = '0;
        // Scan from the top so the lowest-indexed set bit is the one kept.
        for (int unsigned i = 15; i > 0; i--) begin
            if (wb_exc[i-1]) sel = 4'(i - 1);
        end
        if (int_pend) begin
            nxt_exc = 1'b1;
        end else if (|wb_exc) begin
            nxt_exc = 1'b1;
            case (sel)
                4'd0, 4'd9:   nxt_excode = 6'h08;
                4'd1, 4'd10:  nxt_excode = 6'h3F;
                4'd2:         nxt_excode = 6'h03;
                4'd3, 4'd14:  nxt_excode = 6'h07;
                4'd4:         nxt_excode = 6'h0D;
                4'd5:         nxt_excode = 6'h0E;
                4'd6:         nxt_excode = 6'h0B;
                4'd7:         nxt_excode = 6'h0C;
                4'd8:         nxt_excode = 6'h09;
                4'd11:        nxt_excode = 6'h01;
                4'd12:        nxt_excode = 6'h02;
                4'd13:        nxt_excode = 6'h04;
                default:      nxt_excode = 6'h00;
            endcase
            if (sel == 4'd9) nxt_esubcode = 9'd1;
            if (sel <= 4'd3)
                nxt_badv = wb_pc;
            else if (sel >= 4'd8)
                nxt_badv = wb_badv;
        end else if (wb_is_ertn) begin
            nxt_ertn = 1'b1;
        end else if (wb_is_refetch) begin
            nxt_refetch = 1'b1;
        end
    end

`ifdef EXC_TIMEOUT_EN
    localparam int unsigned CW = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
    logic [CW-1:0] to_cnt;
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            state          <= IDLE;
            is_exc         <= 1'b0;
            is_ertn        <= 1'b0;
            is_fetch_again <= 1'b0;
            excode         <= '0;
            esubcode       <= '0;
            badvaddr       <= '0;
            csr_pc         <= '0;
`ifdef EXC_TIMEOUT_EN
            to_cnt         <= '0;
            err_timeout    <= 1'b0;
`endif
        end else begin
            is_exc         <= 1'b0;
            is_ertn        <= 1'b0;
            is_fetch_again <= 1'b0;
            excode         <= '0;
            esubcode       <= '0;
            badvaddr       <= '0;
            csr_pc         <= '0;
            case (state)
                IDLE: begin
                    if (wb_valid && (nxt_exc || nxt_ertn || nxt_refetch)) begin
                        state          <= ISSUE;
                        is_exc         <= nxt_exc;
                        is_ertn        <= nxt_ertn;
                        is_fetch_again <= nxt_refetch;
                        excode         <= nxt_excode;
                        esubcode       <= nxt_esubcode;
                        badvaddr       <= nxt_badv;
                        csr_pc         <= wb_pc;
                    end
                end
                ISSUE: state <= WAIT;
                WAIT: begin
                    if (exlike) begin
                        state <= IDLE;
`ifdef EXC_TIMEOUT_EN
                        to_cnt <= '0;
                    end else if (to_cnt == CW'(TIMEOUT_CYC - 1)) begin
                        state       <= IDLE;
                        to_cnt      <= '0;
                        err_timeout <= 1'b1;
                    end else begin
                        to_cnt <= to_cnt + 1'b1;
`endif
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

`ifndef EXC_TIMEOUT_EN
    assign err_timeout = 1'b0;
`endif

endmodule
